// File: rtl/regfile_sb.sv
// regfile_sb: MIPS register file with a link write port and a busy scoreboard.
//
// Holds registers 1..2**ADDR_W-1. Register 0 is not stored and always reads as
// zero with a zero busy bit. SP_INDEX resets to SP_INIT and every other
// register resets to zero.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   rd_addr1/2              read indices
//   rd_data1/2              combinational read data
//   rd_busy1/2              busy bit of the addressed register (value before the edge)
//   wr_en/wr_addr/wr_data   general writeback port (port A)
//   link_en/link_data       link port (port B), always writes LINK_INDEX
//   issue_en/issue_addr     marks a destination register as having a pending producer
//   flush                   clears every busy bit
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read of a register that is committing
//                      this cycle returns the write data combinationally.
//                      Port A takes priority over port B. Index 0 is never
//                      bypassed, and rd_busy is not affected.

module regfile_sb #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 5,
    parameter int                SP_INDEX   = 29,
    parameter logic [DATA_W-1:0] SP_INIT    = 32'h000000fc,
    parameter int                LINK_INDEX = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              link_en,
    input  logic [DATA_W-1:0] link_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              flush
);

    localparam int                N_REGS    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_ADDR = LINK_INDEX[ADDR_W-1:0];

    logic [DATA_W-1:0] regs [1:N_REGS-1];
    logic [N_REGS-1:1] busy;
    logic [N_REGS-1:1] busy_nxt;

    logic commit_a;
    logic commit_b;

    // Port A is dropped only for index 0. Port B yields to port A when both
    // target the link register, because the writeback result is the younger one.
    assign commit_a = wr_en && (wr_addr != '0);
    assign commit_b = link_en && (LINK_ADDR != '0) && !(commit_a && (wr_addr == LINK_ADDR));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < N_REGS; i++) begin
                regs[i] <= (i == SP_INDEX) ? SP_INIT : '0;
            end
        end else begin
            if (commit_a) begin
                regs[wr_addr] <= wr_data;
            end
            if (commit_b) begin
                regs[LINK_ADDR] <= link_data;
            end
        end
    end

    // A committing write clears its target's busy bit. An issue applied after
    // that takes priority, because the newly issued producer supersedes the
    // write landing now. The issue also takes priority over flush.
    always_comb begin
        busy_nxt = flush ? '0 : busy;
        if (commit_a) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (commit_b) begin
            busy_nxt[LINK_ADDR] = 1'b0;
        end
        if (issue_en && (issue_addr != '0)) begin
            busy_nxt[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        if (addr == '0) begin
            val = '0;
        end else begin
            val = regs[addr];
`ifdef REGFILE_BYPASS_EN
            if (commit_a && (wr_addr == addr)) begin
                val = wr_data;
            end else if (commit_b && (LINK_ADDR == addr)) begin
                val = link_data;
            end
`endif
        end
        return val;
    endfunction

    assign rd_data1 = read_port(rd_addr1);
    assign rd_data2 = read_port(rd_addr2);
    assign rd_busy1 = (rd_addr1 == '0) ? 1'b0 : busy[rd_addr1];
    assign rd_busy2 = (rd_addr2 == '0) ? 1'b0 : busy[rd_addr2];

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb at its default parameters (32 x 32 bits, r29 = SP).
// A behavioural model holds the expected register values and busy bits and is
// updated at each rising edge from the inputs driven in that cycle.

module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr1, rd_addr2;
    logic [31:0] rd_data1, rd_data2;
    logic        rd_busy1, rd_busy2;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        link_en;
    logic [31:0] link_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        flush;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    regfile_sb dut (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .link_en(link_en), .link_data(link_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .flush(flush)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = (i == 29) ? 32'h000000fc : 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        link_en = 0; link_data = 0;
        issue_en = 0; issue_addr = 0; flush = 0;
    endtask

    // Expected read value in the current cycle, taking the build option into account.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
        if (link_en && a == 5'd31) return link_data;
`endif
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input logic [4:0] a);
        return (a == 0) ? 1'b0 : m_busy[a];
    endfunction

    // Advance one clock cycle. The model applies the edge, and the task returns
    // at the following falling edge so that new inputs can be driven.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            bit a_ok, b_ok;
            a_ok = wr_en && (wr_addr != 0);
            b_ok = link_en && !(a_ok && wr_addr == 5'd31);
            if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            if (a_ok) begin m_regs[wr_addr] = wr_data; m_busy[wr_addr] = 1'b0; end
            if (b_ok) begin m_regs[31] = link_data; m_busy[31] = 1'b0; end
            if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1; idle(); rd_addr1 = 0; rd_addr2 = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        reset = 0;
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
            #1;
            checks++;
            if (rd_data1 !== ((i == 29) ? 32'h000000fc : 32'h0)) begin
                errors++; $display("FAIL reset_data r%0d: got %h expected %h", i, rd_data1, (i == 29) ? 32'h000000fc : 32'h0);
            end
            checks++;
            if (rd_busy1 !== 1'b0 || rd_busy2 !== 1'b0) begin
                errors++; $display("FAIL reset_busy r%0d: got %b/%b expected 0/0", i, rd_busy1, rd_busy2);
            end
        end
        wr_en = 1; wr_addr = 5; wr_data = 32'h1234;
        tick(); idle(); rd_addr1 = 5;
        #1;
        checks++;
        if (rd_data1 !== 32'h1234) begin
            errors++; $display("FAIL write_before_reset: got %h expected 00001234", rd_data1);
        end
        #1 reset = 1; model_reset();
        wr_en = 1; wr_addr = 6; wr_data = 32'hCAFE; issue_en = 1; issue_addr = 6;
        #1;
        checks++;
        if (rd_data1 !== 32'h0) begin
            errors++; $display("FAIL midcycle_reset: got %h expected 00000000", rd_data1);
        end
        tick(); idle(); rd_addr2 = 6;
        reset = 0;
        #1;
        checks++;
        if (rd_data2 !== 32'h0 || rd_busy2 !== 1'b0) begin
            errors++; $display("FAIL write_during_reset: got %h busy %b expected 00000000 busy 0", rd_data2, rd_busy2);
        end
    endtask

    task automatic test_dual_write();
        idle();
        wr_en = 1; wr_addr = 31; wr_data = 32'hAAAA0000;
        link_en = 1; link_data = 32'h00400008; rd_addr1 = 31;
        #1;
        checks++;
        if (rd_data1 !== exp_rd(31)) begin
            errors++; $display("FAIL same_cycle_r31: got %h expected %h", rd_data1, exp_rd(31));
        end
        tick(); idle(); rd_addr1 = 31;
        #1;
        checks++;
        if (rd_data1 !== 32'hAAAA0000) begin
            errors++; $display("FAIL collision_port_a_wins: got %h expected aaaa0000", rd_data1);
        end
        wr_en = 1; wr_addr = 8; wr_data = 32'hAAAA0000;
        link_en = 1; link_data = 32'h00400008;
        tick(); idle(); rd_addr1 = 8; rd_addr2 = 31;
        #1;
        checks++;
        if (rd_data1 !== 32'hAAAA0000 || rd_data2 !== 32'h00400008) begin
            errors++; $display("FAIL dual_commit: got r8=%h r31=%h expected aaaa0000/00400008", rd_data1, rd_data2);
        end
    endtask

    task automatic test_zero();
        idle();
        wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
        issue_en = 1; issue_addr = 0; rd_addr1 = 0; rd_addr2 = 0;
        #1;
        checks++;
        if (rd_data1 !== 32'h0 || rd_busy1 !== 1'b0) begin
            errors++; $display("FAIL r0_same_cycle: got %h busy %b expected 00000000 busy 0", rd_data1, rd_busy1);
        end
        tick(); idle();
        #1;
        checks++;
        if (rd_data2 !== 32'h0 || rd_busy2 !== 1'b0) begin
            errors++; $display("FAIL r0_after_write: got %h busy %b expected 00000000 busy 0", rd_data2, rd_busy2);
        end
    endtask

    task automatic test_scoreboard();
        idle(); issue_en = 1; issue_addr = 7; rd_addr1 = 7;
        #1;
        checks++;
        if (rd_busy1 !== 1'b0) begin
            errors++; $display("FAIL busy_not_bypassed: got %b expected 0", rd_busy1);
        end
        tick(); idle();
        #1;
        checks++;
        if (rd_busy1 !== 1'b1) begin
            errors++; $display("FAIL issue_sets_busy: got %b expected 1", rd_busy1);
        end
        wr_en = 1; wr_addr = 7; wr_data = 32'h55; issue_en = 1; issue_addr = 7;
        tick(); idle();
        #1;
        checks++;
        if (rd_data1 !== 32'h55 || rd_busy1 !== 1'b1) begin
            errors++; $display("FAIL set_beats_clear: got %h busy %b expected 00000055 busy 1", rd_data1, rd_busy1);
        end
        wr_en = 1; wr_addr = 7; wr_data = 32'h66;
        tick(); idle();
        #1;
        checks++;
        if (rd_busy1 !== 1'b0) begin
            errors++; $display("FAIL write_clears_busy: got %b expected 0", rd_busy1);
        end
        link_en = 1; link_data = 32'h1; issue_en = 1; issue_addr = 31;
        tick(); idle(); link_en = 1; link_data = 32'h2; rd_addr2 = 31;
        tick(); idle();
        #1;
        checks++;
        if (rd_busy2 !== 1'b0 || rd_data2 !== 32'h2) begin
            errors++; $display("FAIL link_clears_busy: got busy %b data %h expected busy 0 data 00000002", rd_busy2, rd_data2);
        end
        issue_en = 1; issue_addr = 3; tick();
        issue_addr = 9; tick();
        idle(); rd_addr1 = 3; rd_addr2 = 9;
        #1;
        checks++;
        if (rd_busy1 !== 1'b1 || rd_busy2 !== 1'b1) begin
            errors++; $display("FAIL two_issued: got %b/%b expected 1/1", rd_busy1, rd_busy2);
        end
        flush = 1; issue_en = 1; issue_addr = 4;
        tick(); idle();
        #1;
        checks++;
        if (rd_busy1 !== 1'b0 || rd_busy2 !== 1'b0) begin
            errors++; $display("FAIL flush_clears: got %b/%b expected 0/0", rd_busy1, rd_busy2);
        end
        rd_addr1 = 4;
        #1;
        checks++;
        if (rd_busy1 !== 1'b1) begin
            errors++; $display("FAIL issue_beats_flush: got %b expected 1", rd_busy1);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        idle(); rd_addr1 = 12;
        wr_en = 1; wr_addr = 12; wr_data = 32'hDEADBEEF;
`ifdef REGFILE_BYPASS_EN
        want = 32'hDEADBEEF;
`else
        want = 32'h0;
`endif
        #1;
        checks++;
        if (rd_data1 !== want) begin
            errors++; $display("FAIL same_cycle_read_r12: got %h expected %h", rd_data1, want);
        end
        tick(); idle();
        #1;
        checks++;
        if (rd_data1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL next_cycle_read_r12: got %h expected deadbeef", rd_data1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            wr_data    = $urandom;
            link_en    = ($urandom_range(0, 3) == 0);
            link_data  = $urandom;
            issue_en   = 1'($urandom_range(0, 1));
            issue_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            flush      = ($urandom_range(0, 15) == 0);
            rd_addr1   = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr2   = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (rd_data1 !== exp_rd(rd_addr1) || rd_busy1 !== exp_busy(rd_addr1)) begin
                errors++; $display("FAIL random_port1 r%0d: got %h busy %b expected %h busy %b", rd_addr1, rd_data1, rd_busy1, exp_rd(rd_addr1), exp_busy(rd_addr1));
            end
            checks++;
            if (rd_data2 !== exp_rd(rd_addr2) || rd_busy2 !== exp_busy(rd_addr2)) begin
                errors++; $display("FAIL random_port2 r%0d: got %h busy %b expected %h busy %b", rd_addr2, rd_data2, rd_busy2, exp_rd(rd_addr2), exp_busy(rd_addr2));
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_zero();
        test_scoreboard();
        test_bypass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor register file for the 5-stage MIPS pipeline, sitting between ID (read) and WB (write). It provides two asynchronous read ports and two independent write ports: a general writeback port and a dedicated link port for jal/jalr return addresses. Both write ports can commit in the same cycle. A per-register busy scoreboard lets the hazard unit detect in-flight producers, such as load-use cases. Optional write-to-read bypass removes the WB→ID forwarding path.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; register count = 2**ADDR_W
- SP_INDEX, 29, register loaded with SP_INIT on reset
- SP_INIT, 32'h000000fc, stack pointer reset value
- LINK_INDEX, 31, register written by the link port

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- rd_addr1, rd_addr2  in  ADDR_W  read indices
- rd_data1, rd_data2  out  DATA_W  read data, combinational
- rd_busy1, rd_busy2  out  1  scoreboard bit of the addressed register
- wr_en  in  1  writeback port enable
- wr_addr  in  ADDR_W  writeback index
- wr_data  in  DATA_W  writeback data
- link_en  in  1  link port enable (writes LINK_INDEX)
- link_data  in  DATA_W  link value (PC+4)
- issue_en  in  1  mark a destination as pending
- issue_addr  in  ADDR_W  destination being issued
- flush  in  1  clear all busy bits

## Operation
- Register 0:
  - Not stored. Reads always return 0 and rd_busy reports 0.
  - Writes, issues and busy marks to index 0 are ignored.
- Write ports:
  - Port A commits when wr_en=1 and wr_addr≠0.
  - Port B commits link_data to LINK_INDEX when link_en=1.
  - Both commit in the same cycle when targeting different registers.
  - If wr_en=1 with wr_addr=LINK_INDEX and link_en=1, port A wins and port B is dropped.
- Scoreboard: one busy bit per register 1..2**ADDR_W-1.
  - Set: issue_en=1 sets busy[issue_addr].
  - Clear: a committed write from either port clears busy of its target.
  - Set and clear on the same register in the same cycle: set wins, because the new producer supersedes the old one.
  - flush=1 clears all busy bits. A same-cycle issue is still applied, so set wins over flush.
- Reads are purely combinational from the array. rd_busy reflects busy state before the current edge; there is no bypass of issue or clear.

## Timing
- Reset values (asynchronous):
  - all registers = 0, except SP_INDEX = SP_INIT
  - all busy bits = 0
  - so rd_data = 0 for all indices except SP_INDEX, and rd_busy = 0
- Writes and scoreboard updates take effect on the rising edge of clk; they are visible on the read ports from the following cycle (BYPASS_EN off).
- Read latency: 0 cycles (combinational).
- Reset asserted mid-operation:
  - immediately restores the reset values
  - writes, issue and flush presented in that cycle are lost
  - no write lands after reset is released unless its enables are still high at the next edge

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose index matches a committing write in the same cycle returns the write data combinationally.
  - Port A has priority over port B, matching the commit rule.
  - Index 0 is never bypassed.
  - rd_busy is unaffected by bypass.
- Undefined: reads return the pre-edge array contents; the pipeline must forward WB→ID externally.

## Test plan
- Reset, then read all 32 indices → r29=0x000000fc, all others 0, all rd_busy=0. Then write r5=0x1234, assert reset mid-cycle and read r5 → 0.
- Same cycle: wr_en=1, wr_addr=31, wr_data=0xAAAA0000 and link_en=1, link_data=0x00400008 → next cycle r31=0xAAAA0000. With wr_addr=8 instead → r8=0xAAAA0000 and r31=0x00400008.
- wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF; issue_addr=0 → r0 reads 0 and rd_busy for index 0 stays 0.
- issue r7 → rd_busy=1 from the next cycle. Write r7=0x55 together with issue r7 in the same cycle → r7=0x55 and busy stays 1. Write r7 alone → busy=0. Issue r3 and r9, then flush → both busy=0.
- rd_addr1=12 while writing r12=0xDEADBEEF in the same cycle → 0xDEADBEEF with REGFILE_BYPASS_EN defined, the old value 0 without it. The next cycle reads 0xDEADBEEF in both builds.
